// File: rtl/ex_trap_ctrl.sv
// ex_trap_ctrl: external interrupt request controller feeding the core's
// external trap port.
//
// Each raw source passes through a three-flop synchroniser. Edge-type sources
// latch a rising edge into a pending bit. Level-type sources expose the
// synchronised level directly. Enabled pending requests are arbitrated by
// fixed priority, where the lowest index wins. The winner is then offered to
// the core on a valid/ready handshake.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-high reset
//   irq_src             raw interrupt sources (asynchronous to clk)
//   irq_en              per-source enable (synchronous to clk)
//   core_ex_trap_valid  registered request to the core
//   core_ex_trap_ready  core accepts the request
//   trap_id             index of the requesting source, stable while valid
//   pend                pending vector before enable masking
//   trap_cnt            number of completed handshakes (wraps)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; picks a winner when any request is seen
// REQ   | valid held high with a fixed trap_id until the core accepts
// HOLD  | one forced low cycle on valid after each handshake
module ex_trap_ctrl #(
  parameter int                 SRC_NUM   = 8,
  parameter int                 ID_W      = 3,
  parameter logic [SRC_NUM-1:0] EDGE_MASK = {SRC_NUM{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] irq_src,
  input  logic [SRC_NUM-1:0] irq_en,
  output logic               core_ex_trap_valid,
  input  logic               core_ex_trap_ready,
  output logic [ID_W-1:0]    trap_id,
  output logic [SRC_NUM-1:0] pend,
  output logic [15:0]        trap_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SRC_NUM-1:0] s1_q, s2_q, s3_q;
  logic [SRC_NUM-1:0] pend_edge_q, pend_edge_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    trap_id_q, trap_id_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [SRC_NUM-1:0] edge_evt;
  logic [SRC_NUM-1:0] pend_clr;
  logic [SRC_NUM-1:0] req;
  logic [ID_W-1:0]    win_id;
  logic               hs;

  assign edge_evt = s2_q & ~s3_q;

  // Level sources have no storage; they simply mirror the synchronised input.
  assign pend = (pend_edge_q & EDGE_MASK) | (s2_q & ~EDGE_MASK);
  assign req  = pend & irq_en;
  assign hs   = (state_q == REQ) && valid_q && core_ex_trap_ready;

  // Walk from the top down so that the lowest set index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      pend_clr[i] = hs && (trap_id_q == ID_W'(i));
    end
  end

  // The set term is ORed in after the clear, so a new edge arriving on the
  // handshake cycle is kept.
  assign pend_edge_d = ((pend_edge_q & ~pend_clr) | edge_evt) & EDGE_MASK;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    trap_id_d = trap_id_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          valid_d   = 1'b1;
          trap_id_d = win_id;
          state_d   = REQ;
        end
      end
      REQ: begin
        // No retraction: the request holds even if its source goes away.
        if (hs) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pend_edge_q <= '0;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      trap_id_q   <= '0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= irq_src;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pend_edge_q <= pend_edge_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      trap_id_q   <= trap_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign core_ex_trap_valid = valid_q;
  assign trap_id            = trap_id_q;
  assign trap_cnt           = cnt_q;

endmodule

// File: tb/tb_ex_trap_ctrl.sv
module tb_ex_trap_ctrl;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst = 1'b0;
  logic [7:0] irq_src = '0;
  logic [7:0] irq_en = '0;
  logic       ready = 1'b0;
  logic       valid;
  logic [2:0] trap_id;
  logic [7:0] pend;
  logic [15:0] trap_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // Source 0 is level type; all others are edge captured.
  ex_trap_ctrl #(.SRC_NUM(8), .ID_W(3), .EDGE_MASK(8'hFE)) dut (
    .clk                (clk),
    .rst                (rst),
    .irq_src            (irq_src),
    .irq_en             (irq_en),
    .core_ex_trap_valid (valid),
    .core_ex_trap_ready (ready),
    .trap_id            (trap_id),
    .pend               (pend),
    .trap_cnt           (trap_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_id", 32'(trap_id), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_cnt", 32'(trap_cnt), 32'd0);
    tick(2);
    rst = 1'b0;
    irq_en = 8'hFF;
    tick(2);

    // Single edge on source 2
    irq_src[2] = 1'b1;
    tick(1);                    // edge N
    tick(1); irq_src[2] = 1'b0; // N+1
    tick(1);                    // N+2
    check("se_pend", 32'(pend), 32'h04);
    check("se_valid_early", 32'(valid), 32'd0);
    tick(1);                    // N+3
    check("se_valid", 32'(valid), 32'd1);
    check("se_id", 32'(trap_id), 32'd2);
    tick(1);                    // N+4
    check("se_valid_hold", 32'(valid), 32'd1);
    ready = 1'b1;
    tick(1);                    // N+5 handshake
    exp_cnt++;
    check("se_valid_drop", 32'(valid), 32'd0);
    check("se_pend_clr", 32'(pend), 32'd0);
    check("se_cnt", 32'(trap_cnt), 32'(exp_cnt));
    check("se_id_keep", 32'(trap_id), 32'd2);
    tick(3);

    // Priority: sources 5 and 1 together, ready tied high
    irq_src[5] = 1'b1; irq_src[1] = 1'b1;
    tick(1);
    tick(1); irq_src = '0;
    tick(1);
    check("pr_pend", 32'(pend), 32'h22);
    tick(1);
    check("pr_valid1", 32'(valid), 32'd1);
    check("pr_id1", 32'(trap_id), 32'd1);
    tick(1);
    exp_cnt++;
    check("pr_hs1_valid", 32'(valid), 32'd0);
    check("pr_hs1_pend", 32'(pend), 32'h20);
    check("pr_hs1_cnt", 32'(trap_cnt), 32'(exp_cnt));
    tick(1);
    check("pr_hold", 32'(valid), 32'd0);
    tick(1);
    check("pr_valid2", 32'(valid), 32'd1);
    check("pr_id2", 32'(trap_id), 32'd5);
    tick(1);
    exp_cnt++;
    check("pr_hs2_pend", 32'(pend), 32'd0);
    check("pr_hs2_cnt", 32'(trap_cnt), 32'(exp_cnt));
    ready = 1'b0;
    tick(3);

    // Level source 0 held high, ready held high
    ready = 1'b1;
    irq_src[0] = 1'b1;
    tick(1);                    // N
    tick(1);                    // N+1
    check("lv_pend", 32'(pend), 32'h01);
    tick(1);                    // N+2
    check("lv_valid1", 32'(valid), 32'd1);
    check("lv_id1", 32'(trap_id), 32'd0);
    tick(1);                    // N+3
    exp_cnt++;
    check("lv_cnt1", 32'(trap_cnt), 32'(exp_cnt));
    check("lv_pend_kept", 32'(pend), 32'h01);
    tick(2);                    // N+5
    check("lv_valid2", 32'(valid), 32'd1);
    tick(1);                    // N+6
    exp_cnt++;
    check("lv_cnt2", 32'(trap_cnt), 32'(exp_cnt));
    irq_src[0] = 1'b0;
    tick(1);                    // N+7
    check("lv_pend_s2", 32'(pend), 32'h01);
    tick(1);                    // N+8
    check("lv_pend_drop", 32'(pend), 32'h00);
    check("lv_valid3", 32'(valid), 32'd1);
    tick(1);                    // N+9
    exp_cnt++;
    tick(4);
    check("lv_quiet", 32'(valid), 32'd0);
    check("lv_cnt3", 32'(trap_cnt), 32'(exp_cnt));
    ready = 1'b0;

    // Enable masking on source 3
    irq_en = 8'hF7;
    irq_src[3] = 1'b1;
    tick(1);
    tick(1); irq_src[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("en_masked", 32'(valid), 32'd0);
    end
    check("en_pend", 32'(pend), 32'h08);
    irq_en = 8'hFF;
    tick(1);
    check("en_valid", 32'(valid), 32'd1);
    check("en_id", 32'(trap_id), 32'd3);
    ready = 1'b1;
    tick(1);
    exp_cnt++;
    check("en_cnt", 32'(trap_cnt), 32'(exp_cnt));
    check("en_pend_clr", 32'(pend), 32'd0);
    ready = 1'b0;
    tick(3);

    // Collision: new edge on source 4 lands on the clearing handshake
    irq_src[4] = 1'b1;
    tick(1);                    // N
    tick(1); irq_src[4] = 1'b0; // N+1
    tick(1);                    // N+2
    check("co_pend", 32'(pend), 32'h10);
    tick(1);                    // N+3
    check("co_valid1", 32'(valid), 32'd1);
    check("co_id1", 32'(trap_id), 32'd4);
    irq_src[4] = 1'b1;
    tick(2);                    // N+5
    irq_src[4] = 1'b0;
    ready = 1'b1;
    tick(1);                    // N+6 handshake + new edge
    exp_cnt++;
    check("co_pend_kept", 32'(pend), 32'h10);
    check("co_hs1_valid", 32'(valid), 32'd0);
    check("co_cnt1", 32'(trap_cnt), 32'(exp_cnt));
    tick(1);
    check("co_hold", 32'(valid), 32'd0);
    tick(1);                    // N+8
    check("co_valid2", 32'(valid), 32'd1);
    check("co_id2", 32'(trap_id), 32'd4);
    tick(1);                    // N+9
    exp_cnt++;
    check("co_cnt2", 32'(trap_cnt), 32'(exp_cnt));
    check("co_pend_clr", 32'(pend), 32'd0);
    ready = 1'b0;
    tick(3);

    // Asynchronous reset mid-REQ with the clock stopped
    irq_src[2] = 1'b1;
    tick(1);
    tick(1); irq_src[2] = 1'b0;
    tick(2);
    check("ar_valid_pre", 32'(valid), 32'd1);
    check("ar_cnt_pre", 32'(trap_cnt), 32'(exp_cnt));
    @(negedge clk);
    #1 clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(valid), 32'd0);
    check("ar_pend", 32'(pend), 32'd0);
    check("ar_cnt", 32'(trap_cnt), 32'd0);
    check("ar_id", 32'(trap_id), 32'd0);
    #5 rst = 1'b0;
    #5 clk_run = 1'b1;
    tick(6);
    check("ar_post_valid", 32'(valid), 32'd0);
    check("ar_post_pend", 32'(pend), 32'd0);
    check("ar_post_cnt", 32'(trap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_trap_ctrl.md
Name: ex_trap_ctrl

Overview:
External interrupt request controller that sits directly upstream of the core's external trap port in sparrow_soc. It collects SRC_NUM asynchronous interrupt sources and synchronises them. Each source is either edge-captured into a pending register or passed through as a level. Enabled requests are arbitrated by fixed priority, and the winner is presented on the core_ex_trap_valid/core_ex_trap_ready handshake together with the winning source ID.

Parameters:
SRC_NUM, 8, number of interrupt sources (2..32)
ID_W, 3, width of trap_id; must satisfy 2**ID_W >= SRC_NUM
EDGE_MASK, 8'hFF, per-source type: bit=1 means rising-edge captured, bit=0 means level

Ports:
clk  input  1  system clock
rst  input  1  reset
irq_src  input  SRC_NUM  raw interrupt sources, asynchronous to clk
irq_en  input  SRC_NUM  per-source enable, synchronous to clk
core_ex_trap_valid  output  1  request to core, registered
core_ex_trap_ready  input  1  core accepts request
trap_id  output  ID_W  index of the requesting source; stable while valid=1
pend  output  SRC_NUM  current pending vector, before enable masking
trap_cnt  output  16  count of completed handshakes, wraps at 16'hFFFF -> 0

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: while rst=1, all flops clear immediately without waiting for clk. core_ex_trap_valid=0, trap_id=0, pend=0, trap_cnt=0, FSM=IDLE. A reset during REQ drops valid in the same instant.
- Synchroniser: per source, flops s1 -> s2 -> s3, all reset to 0. The edge event is s2 & ~s3.
- Pending, edge source:
  - bit set on an edge event;
  - bit cleared on a handshake that selected it;
  - set wins over a simultaneous clear, so a new event is never lost.
- Pending, level source: pend bit = s2, with no storage. Handshake clear has no effect on it.
- Capture is independent of irq_en. Disabled edge events remain pending.
- Request vector: req = pend & irq_en. Winner = lowest set index.
- Latency: a source first sampled high at edge N gives s2=1 at N+1 and pend=1 at N+2. Valid=1 at N+3 if the FSM is IDLE and the source is enabled. For a level source, pend=1 at N+1 and valid=1 at N+2.
- FSM:
  - IDLE: if req != 0, register trap_id=winner and valid=1, then go to REQ. Otherwise stay in IDLE.
  - REQ: hold valid=1 and trap_id. Handshake occurs on a clk edge with valid=1 and ready=1. On handshake:
    - valid<=0;
    - clear pend[trap_id] if it is an edge source;
    - trap_cnt<=trap_cnt+1;
    - go to HOLD.
  - REQ has no retraction. The request stays asserted even if the selected source deasserts or is disabled.
  - HOLD: one idle cycle with valid=0, then go to IDLE. This guarantees at least one low cycle between requests.
- Ready asserted before valid is allowed; the handshake occurs on the first edge where valid=1. Ready while valid=0 is ignored.
- Level source held high with ready held high produces back-to-back handshakes with a period of 3 cycles.
- trap_id keeps its last value after a handshake until the next IDLE->REQ transition.
- Irq sources must stay high for at least 2 clk periods to be guaranteed captured.

Test Plan:
- Reset: pulse irq_src[2], assert rst mid-REQ with clk stopped -> valid=0, pend=0, trap_cnt=0 immediately; after rst release all outputs remain 0.
- Single edge: irq_en=8'hFF, irq_src[2] rises before edge N -> valid=1 at N+3 with trap_id=2; ready=1 sampled at N+5 -> valid=0 after N+5, pend[2]=0, trap_cnt=1.
- Priority: irq_src[5] and irq_src[1] rise together, ready tied 1 -> first handshake trap_id=1; valid low for one cycle (HOLD); second handshake trap_id=5; trap_cnt=2, pend=0.
- Level: EDGE_MASK=8'hFE, irq_src[0] held high, ready tied 1 -> handshakes every 3 cycles with trap_id=0; after src drops, at most one further handshake, and pend[0] follows s2.
- Enable masking: irq_en[3]=0, pulse irq_src[3] -> pend[3]=1, valid stays 0 for 20 cycles; set irq_en[3]=1 at edge M -> valid=1 at M+1, trap_id=3.
- Collision: edge source 4 has a new event on the same edge as the handshake that clears pend[4] -> pend[4] stays 1 and a second request with trap_id=4 follows after HOLD; trap_cnt increments twice.
